// File: rtl/thermistor_adc_sampler.sv
// thermistor_adc_sampler
// Periodically reads a 10-bit serial ADC that digitises the thermistor divider.
// It averages 2^AVG_LOG2 conversions and publishes the top 8 bits of the average.
// Ports:
//   clock, reset   : system clock; asynchronous active-high reset
//   enable         : allows new conversion frames to start
//   adc_miso       : ADC serial data, MSB first
//   adc_cs_n       : ADC chip select (active low), registered
//   adc_sclk       : ADC serial clock (idles low), registered
//   temp_code[7:0] : latest averaged code, holds between updates
//   temp_valid     : one-cycle pulse when temp_code updates
//   busy           : high while a conversion frame is in progress
module thermistor_adc_sampler #(
   parameter int unsigned CLK_DIV       = 4,
   parameter int unsigned SAMPLE_PERIOD = 1000,
   parameter int unsigned AVG_LOG2      = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       adc_miso,
   output logic       adc_cs_n,
   output logic       adc_sclk,
   output logic [7:0] temp_code,
   output logic       temp_valid,
   output logic       busy
);

   localparam int unsigned PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned AW = 10 + AVG_LOG2;
   localparam int unsigned CW = AVG_LOG2 + 1;

   localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(1 << AVG_LOG2);

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_ACCUM, S_PUBLISH} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] per_q, per_d;
   logic [DW-1:0] div_q, div_d;
   logic [4:0]    half_q, half_d;
   logic [9:0]    sh_q, sh_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cs_n_q, cs_n_d;
   logic          sclk_q, sclk_d;
   logic          busy_q, busy_d;
   logic [7:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          wrap;

   assign wrap = enable && (per_q == PER_LAST);

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         per_q   <= '0;
         div_q   <= '0;
         half_q  <= '0;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         busy_q  <= 1'b0;
         code_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         div_q   <= div_d;
         half_q  <= half_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         busy_q  <= busy_d;
         code_q  <= code_d;
         valid_q <= valid_d;
      end
   end

   // Next-state logic: period counter, serial frame sequencing, averaging
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      half_d  = half_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      busy_d  = busy_q;
      code_d  = code_q;
      valid_d = 1'b0;

      // Free-running period counter; keeps counting through the frame
      if (!enable || wrap) per_d = '0;
      else                 per_d = per_q + PW'(1);

      case (state_q)
         S_IDLE: begin
            if (wrap) begin
               state_d = S_CONV;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               sclk_d  = 1'b0;
               div_d   = '0;
               half_d  = '0;
            end
         end
         S_CONV: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               half_d = half_q + 5'd1;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  // Rising edge number is half_q[4:1]+1; only edges 4..13 carry data
                  if (half_q[4:1] >= 4'd3 && half_q[4:1] <= 4'd12)
                     sh_d = {sh_q[8:0], adc_miso};
               end else begin
                  sclk_d = 1'b0;
                  // 16th falling edge closes the frame
                  if (half_q == 5'd31) begin
                     state_d = S_ACCUM;
                     cs_n_d  = 1'b1;
                     busy_d  = 1'b0;
                  end
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         S_ACCUM: begin
            state_d = S_IDLE;
            if (!enable) begin
               // Disabled mid-average: drop the partial result
               acc_d = '0;
               cnt_d = '0;
            end else begin
               acc_d = acc_q + AW'(sh_q);
               cnt_d = cnt_q + CW'(1);
               if (cnt_q + CW'(1) == CNT_FULL) state_d = S_PUBLISH;
            end
         end
         S_PUBLISH: begin
            code_d  = acc_q[AVG_LOG2+9 -: 8];
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign adc_cs_n   = cs_n_q;
   assign adc_sclk   = sclk_q;
   assign busy       = busy_q;
   assign temp_code  = code_q;
   assign temp_valid = valid_q;

endmodule
